ex_mem_latch: RTL and testbench

- EX/MEM pipeline boundary directly downstream of the ALU.
- Captures the ALU result and flags along with the execute-stage control bundle, and resolves BEQ/BNE from the ALU zero flag.
- Issues a registered PC redirect, converts signed overflow on trapping ops into a terminal halt, and supports stall/flush from the hazard unit.
- Feeds the memory stage and the datapath PC logic.

---
 rtl/ex_mem_latch_pkg.sv | 34 +++
 rtl/ex_mem_latch_if.sv | 50 +++++
 rtl/ex_mem_latch_branch_resolve.sv | 19 +
 rtl/ex_mem_latch.sv | 146 ++++++++++++++
 tb/tb_ex_mem_latch.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_latch_pkg.sv
// Shared types for the EX/MEM pipeline boundary: word/register types, branch kinds, latch state.
package ex_mem_latch_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned PERF_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } branch_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALT   = 2'd2
  } exmem_state_t;

  // One MEM-stage slot as held in the boundary register.
  typedef struct packed {
    logic     valid;
    word_t    result;
    word_t    store_data;
    regbits_t rd;
    logic     regwen;
    logic     memren;
    logic     memwen;
  } mem_slot_t;

endpackage

// File: rtl/ex_mem_latch_if.sv
// Execute-stage inputs and MEM-stage outputs of the EX/MEM boundary.
interface ex_mem_latch_if;
  import ex_mem_latch_pkg::*;

  logic     stall;
  logic     flush;
  logic     ex_valid;
  word_t    ex_result;
  logic     ex_negative;
  logic     ex_zero;
  logic     ex_overflow;
  word_t    ex_store_data;
  regbits_t ex_rd;
  logic     ex_regwen;
  logic     ex_memren;
  logic     ex_memwen;
  logic     ex_halt;
  logic     ex_ovf_trap;
  branch_t  ex_branch;
  word_t    ex_br_target;

  logic     mem_valid;
  word_t    mem_result;
  word_t    mem_store_data;
  regbits_t mem_rd;
  logic     mem_regwen;
  logic     mem_memren;
  logic     mem_memwen;
  logic     mem_halt;
  logic     redirect;
  word_t    redirect_pc;
  logic     ovf_exc;

  modport master (
    output stall, flush, ex_valid, ex_result, ex_negative, ex_zero, ex_overflow,
           ex_store_data, ex_rd, ex_regwen, ex_memren, ex_memwen, ex_halt,
           ex_ovf_trap, ex_branch, ex_br_target,
    input  mem_valid, mem_result, mem_store_data, mem_rd, mem_regwen, mem_memren,
           mem_memwen, mem_halt, redirect, redirect_pc, ovf_exc
  );

  modport slave (
    input  stall, flush, ex_valid, ex_result, ex_negative, ex_zero, ex_overflow,
           ex_store_data, ex_rd, ex_regwen, ex_memren, ex_memwen, ex_halt,
           ex_ovf_trap, ex_branch, ex_br_target,
    output mem_valid, mem_result, mem_store_data, mem_rd, mem_regwen, mem_memren,
           mem_memwen, mem_halt, redirect, redirect_pc, ovf_exc
  );

endinterface

// File: rtl/ex_mem_latch_branch_resolve.sv
// Resolves BEQ/BNE from the ALU zero flag.
module ex_mem_latch_branch_resolve
  import ex_mem_latch_pkg::*;
(
  input  branch_t ex_branch,
  input  logic    ex_zero,
  output logic    taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (ex_branch)
      BR_EQ:   taken_c = ex_zero;
      BR_NE:   taken_c = !ex_zero;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline boundary: latches ALU results, issues branch redirects, traps overflow to halt.
// Optional performance counters are built when EX_MEM_PERF_EN is defined.
module ex_mem_latch
  import ex_mem_latch_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  ex_mem_latch_if.slave      bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_bubbles,
  output logic [PERF_W-1:0]  perf_taken
`endif
);

  exmem_state_t state_q, state_d;
  mem_slot_t    slot_q, slot_d;
  logic         halt_q, halt_d;
  logic         ovf_q, ovf_d;
  logic         redir_q, redir_d;
  word_t        redir_pc_q, redir_pc_d;

  logic taken_c;
  logic cap_c;
  logic ot_c;
  logic tk_c;
  logic unused_flags;

  ex_mem_latch_branch_resolve u_branch_resolve (
    .ex_branch (bus.ex_branch),
    .ex_zero   (bus.ex_zero),
    .taken_c   (taken_c)
  );

  // Overflow trap outranks a branch; the two never coexist in legal code.
  assign cap_c        = (state_q == RUN) && !bus.stall && !bus.flush && bus.ex_valid;
  assign ot_c         = cap_c && bus.ex_ovf_trap && bus.ex_overflow;
  assign tk_c         = cap_c && taken_c && !ot_c;
  assign unused_flags = bus.ex_negative;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    halt_d     = halt_q;
    ovf_d      = ovf_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
    if (!bus.stall) begin
      slot_d  = '0;
      redir_d = 1'b0;
      case (state_q)
        RUN: begin
          if (cap_c) begin
            slot_d.valid      = 1'b1;
            slot_d.result     = bus.ex_result;
            slot_d.store_data = bus.ex_store_data;
            slot_d.rd         = bus.ex_rd;
            slot_d.regwen     = bus.ex_regwen;
            slot_d.memren     = bus.ex_memren;
            slot_d.memwen     = bus.ex_memwen;
            if (ot_c) begin
              slot_d.regwen = 1'b0;
              slot_d.memwen = 1'b0;
              halt_d        = 1'b1;
              ovf_d         = 1'b1;
              state_d       = HALT;
            end else begin
              if (tk_c) begin
                slot_d.regwen = 1'b0;
                redir_d       = 1'b1;
                redir_pc_d    = bus.ex_br_target;
                state_d       = SQUASH;
              end
              if (bus.ex_halt) begin
                halt_d  = 1'b1;
                state_d = HALT;
              end
            end
          end
        end
        SQUASH:  state_d = RUN;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      slot_q     <= '0;
      halt_q     <= 1'b0;
      ovf_q      <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      halt_q     <= halt_d;
      ovf_q      <= ovf_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign bus.mem_valid      = slot_q.valid;
  assign bus.mem_result     = slot_q.result;
  assign bus.mem_store_data = slot_q.store_data;
  assign bus.mem_rd         = slot_q.rd;
  assign bus.mem_regwen     = slot_q.regwen;
  assign bus.mem_memren     = slot_q.memren;
  assign bus.mem_memwen     = slot_q.memwen;
  assign bus.mem_halt       = halt_q;
  assign bus.redirect       = redir_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.ovf_exc        = ovf_q;

`ifdef EX_MEM_PERF_EN
  logic [PERF_W-1:0] perf_bubbles_q, perf_bubbles_d;
  logic [PERF_W-1:0] perf_taken_q, perf_taken_d;

  // Bubbles are counted on the value being loaded, so stalls never count.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_taken_d   = perf_taken_q;
    if (!bus.stall) begin
      if (!slot_d.valid) perf_bubbles_d = perf_bubbles_q + PERF_W'(1);
      if (tk_c)          perf_taken_d   = perf_taken_q + PERF_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_bubbles_q <= '0;
      perf_taken_q   <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_taken_q   <= perf_taken_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_taken   = perf_taken_q;
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: expected MEM slots are queued at drive time, checked one edge later.
module tb_ex_mem_latch;
  import ex_mem_latch_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  ex_mem_latch_if bus ();

`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_bubbles;
  logic [31:0] perf_taken;
  ex_mem_latch dut (.CLK(CLK), .RST(RST), .bus(bus),
                    .perf_bubbles(perf_bubbles), .perf_taken(perf_taken));
`else
  ex_mem_latch dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

  typedef struct packed {
    logic     stall, flush, valid, regwen, memren, memwen, halt, ovf_trap, overflow, zero;
    branch_t  br;
    word_t    result, store, target;
    regbits_t rd;
  } stim_t;

  typedef struct packed {
    logic     valid, regwen, memren, memwen, halt, ovf, redirect;
    word_t    result, store, rpc;
    regbits_t rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  function automatic stim_t s_nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t s_alu(word_t r, regbits_t rd);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.regwen = 1'b1; s.result = r; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t s_br(branch_t b, logic z, word_t tgt);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.br = b; s.zero = z; s.target = tgt;
    return s;
  endfunction

  function automatic exp_t e_valid(word_t r, regbits_t rd, logic regwen);
    exp_t e;
    e = '0;
    e.valid = 1'b1; e.result = r; e.rd = rd; e.regwen = regwen;
    return e;
  endfunction

  function automatic exp_t e_bub(logic halt, logic ovf);
    exp_t e;
    e = '0;
    e.halt = halt; e.ovf = ovf;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    bus.stall         = s.stall;
    bus.flush         = s.flush;
    bus.ex_valid      = s.valid;
    bus.ex_result     = s.result;
    bus.ex_negative   = s.result[31];
    bus.ex_zero       = s.zero;
    bus.ex_overflow   = s.overflow;
    bus.ex_store_data = s.store;
    bus.ex_rd         = s.rd;
    bus.ex_regwen     = s.regwen;
    bus.ex_memren     = s.memren;
    bus.ex_memwen     = s.memwen;
    bus.ex_halt       = s.halt;
    bus.ex_ovf_trap   = s.ovf_trap;
    bus.ex_branch     = s.br;
    bus.ex_br_target  = s.target;
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb_q.pop_front();
    last_e = e;
    check("mem_valid",  bus.mem_valid,  e.valid);
    check("mem_regwen", bus.mem_regwen, e.regwen);
    check("mem_memren", bus.mem_memren, e.memren);
    check("mem_memwen", bus.mem_memwen, e.memwen);
    check("mem_halt",   bus.mem_halt,   e.halt);
    check("ovf_exc",    bus.ovf_exc,    e.ovf);
    check("redirect",   bus.redirect,   e.redirect);
    if (e.valid) begin
      check("mem_result",     bus.mem_result,     e.result);
      check("mem_store_data", bus.mem_store_data, e.store);
      check("mem_rd",         bus.mem_rd,         e.rd);
    end
    if (e.redirect) check("redirect_pc", bus.redirect_pc, e.rpc);
  endtask

  task automatic step(input stim_t s, input exp_t e);
    @(negedge CLK);
    RST = 1'b0;
    apply(s);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    compare_out();
  endtask

  // Reset is held with stall, flush and a valid instruction present: reset must still win.
  task automatic do_reset();
    stim_t s;
    @(negedge CLK);
    RST = 1'b1;
    s = s_alu(32'hDEAD_BEEF, 5'd1);
    s.stall = 1'b1; s.flush = 1'b1; s.halt = 1'b1;
    apply(s);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_mem_valid",   bus.mem_valid,      32'd0);
    check("rst_mem_result",  bus.mem_result,     32'd0);
    check("rst_mem_store",   bus.mem_store_data, 32'd0);
    check("rst_mem_rd",      bus.mem_rd,         32'd0);
    check("rst_mem_regwen",  bus.mem_regwen,     32'd0);
    check("rst_mem_memren",  bus.mem_memren,     32'd0);
    check("rst_mem_memwen",  bus.mem_memwen,     32'd0);
    check("rst_mem_halt",    bus.mem_halt,       32'd0);
    check("rst_redirect",    bus.redirect,       32'd0);
    check("rst_redirect_pc", bus.redirect_pc,    32'd0);
    check("rst_ovf_exc",     bus.ovf_exc,        32'd0);
    last_e = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    exp_t  e;
    RST = 1'b1;
    apply(s_nop());
    do_reset();

    // Basic capture and a store.
    step(s_alu(32'h0000_00FF, 5'd5), e_valid(32'h0000_00FF, 5'd5, 1'b1));
    s = s_nop(); s.valid = 1'b1; s.memwen = 1'b1; s.store = 32'hCAFE_F00D; s.result = 32'h100;
    e = e_valid(32'h100, 5'd0, 1'b0); e.memwen = 1'b1; e.store = 32'hCAFE_F00D;
    step(s, e);

    // BEQ taken: one-cycle redirect, next instruction squashed, then normal capture.
    e = e_valid(32'h0, 5'd0, 1'b0); e.redirect = 1'b1; e.rpc = 32'h0000_0040;
    step(s_br(BR_EQ, 1'b1, 32'h0000_0040), e);
    step(s_alu(32'h11, 5'd3), e_bub(1'b0, 1'b0));
    step(s_alu(32'h22, 5'd4), e_valid(32'h22, 5'd4, 1'b1));

    // BNE not taken: no redirect, no squash.
    step(s_br(BR_NE, 1'b1, 32'h0000_0060), e_valid(32'h0, 5'd0, 1'b0));
    step(s_alu(32'h33, 5'd6), e_valid(32'h33, 5'd6, 1'b1));

    // Stall for three cycles (one with flush) holds everything.
    for (int i = 0; i < 3; i++) begin
      s = s_alu(32'h900 + word_t'(i), 5'd12);
      s.stall = 1'b1;
      s.flush = (i == 1);
      step(s, last_e);
    end
    s = s_alu(32'h44, 5'd2); s.flush = 1'b1;
    step(s, e_bub(1'b0, 1'b0));

    // Redirect held through a stall, then squash on the first unstalled edge.
    e = e_valid(32'h0, 5'd0, 1'b0); e.redirect = 1'b1; e.rpc = 32'h0000_0080;
    step(s_br(BR_NE, 1'b0, 32'h0000_0080), e);
    for (int i = 0; i < 2; i++) begin
      s = s_alu(32'h50, 5'd7); s.stall = 1'b1;
      step(s, last_e);
    end
    step(s_alu(32'h55, 5'd8), e_bub(1'b0, 1'b0));
    step(s_alu(32'h66, 5'd9), e_valid(32'h66, 5'd9, 1'b1));

    // Overflow trap: terminal halt, later instructions become bubbles.
    s = s_alu(32'h8000_0000, 5'd9); s.ovf_trap = 1'b1; s.overflow = 1'b1;
    e = e_valid(32'h8000_0000, 5'd9, 1'b0); e.halt = 1'b1; e.ovf = 1'b1;
    step(s, e);
    step(s_alu(32'h77, 5'd10), e_bub(1'b1, 1'b1));
    step(s_alu(32'h78, 5'd11), e_bub(1'b1, 1'b1));

    // Reset leaves HALT; a captured ex_halt halts without the overflow flag.
    do_reset();
    step(s_alu(32'h77, 5'd10), e_valid(32'h77, 5'd10, 1'b1));
    s = s_alu(32'h88, 5'd11); s.halt = 1'b1;
    e = e_valid(32'h88, 5'd11, 1'b1); e.halt = 1'b1;
    step(s, e);
    step(s_alu(32'h99, 5'd13), e_bub(1'b1, 1'b0));

`ifdef EX_MEM_PERF_EN
    do_reset();
    e = e_valid(32'h0, 5'd0, 1'b0); e.redirect = 1'b1; e.rpc = 32'h0000_0100;
    step(s_br(BR_EQ, 1'b1, 32'h0000_0100), e);
    step(s_alu(32'h1, 5'd1), e_bub(1'b0, 1'b0));
    e = e_valid(32'h0, 5'd0, 1'b0); e.redirect = 1'b1; e.rpc = 32'h0000_0200;
    step(s_br(BR_NE, 1'b0, 32'h0000_0200), e);
    step(s_alu(32'h2, 5'd2), e_bub(1'b0, 1'b0));
    s = s_alu(32'h3, 5'd3); s.flush = 1'b1;
    step(s, e_bub(1'b0, 1'b0));
    check("perf_taken",   perf_taken,   32'd2);
    check("perf_bubbles", perf_bubbles, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
